// File: rtl/holy_mem_arbiter.sv
// ============================================================================
// holy_mem_arbiter : two-port (I/D) arbiter onto one uncached memory port.
// Optional macro HOLY_ARB_ROUND_ROBIN_EN selects round-robin; default is D>I.
// Revision: 1.0
// ============================================================================
`default_nettype none

module holy_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  input  logic [3:0]  i_byte_enable,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  output logic        i_req_ready,
  output logic [31:0] i_read_data,
  output logic        i_read_valid,
  input  logic        i_read_ack,

  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_byte_enable,
  input  logic        d_req_valid,
  input  logic        d_req_write,
  output logic        d_req_ready,
  output logic [31:0] d_read_data,
  output logic        d_read_valid,
  input  logic        d_read_ack,

  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_req_valid,
  output logic        mem_req_write,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid,
  output logic        mem_read_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t state, state_next;
  logic   owner, owner_next;
  logic   last_grant, last_grant_next;
  logic   winner;

  logic        own_valid;
  logic        own_write;
  logic [31:0] own_address;
  logic [31:0] own_write_data;
  logic [3:0]  own_byte_enable;
  logic        own_read_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
    end
  end

  // Contention resolution only matters when both ports request together.
  always_comb begin
    winner = d_req_valid ? OWN_D : OWN_I;
`ifdef HOLY_ARB_ROUND_ROBIN_EN
    if (i_req_valid && d_req_valid) begin
      winner = ~last_grant;
    end
`endif
  end

  always_comb begin
    own_valid       = (owner == OWN_D) ? d_req_valid   : i_req_valid;
    own_write       = (owner == OWN_D) ? d_req_write   : i_req_write;
    own_address     = (owner == OWN_D) ? d_address     : i_address;
    own_write_data  = (owner == OWN_D) ? d_write_data  : i_write_data;
    own_byte_enable = (owner == OWN_D) ? d_byte_enable : i_byte_enable;
    own_read_ack    = (owner == OWN_D) ? d_read_ack    : i_read_ack;
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_grant_next = last_grant;

    i_req_ready     = 1'b0;
    d_req_ready     = 1'b0;
    i_read_valid    = 1'b0;
    d_read_valid    = 1'b0;
    i_read_data     = 32'd0;
    d_read_data     = 32'd0;
    mem_address     = 32'd0;
    mem_write_data  = 32'd0;
    mem_byte_enable = 4'd0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_read_ack    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_req_valid || d_req_valid) begin
          state_next      = ST_REQ;
          owner_next      = winner;
          last_grant_next = winner;
        end
      end

      ST_REQ: begin
        mem_req_valid   = own_valid;
        mem_req_write   = own_write;
        mem_address     = own_address;
        mem_write_data  = own_write_data;
        mem_byte_enable = own_byte_enable;
        i_req_ready     = (owner == OWN_I) && mem_req_ready;
        d_req_ready     = (owner == OWN_D) && mem_req_ready;
        if (own_valid && mem_req_ready) begin
          state_next = own_write ? ST_IDLE : ST_RESP;
        end else if (!own_valid) begin
          // Requester withdrew before acceptance: abandon without a memory access.
          state_next = ST_IDLE;
        end
      end

      ST_RESP: begin
        mem_read_ack = own_read_ack;
        if (owner == OWN_I) begin
          i_read_valid = mem_read_valid;
          i_read_data  = mem_read_valid ? mem_read_data : 32'd0;
        end else begin
          d_read_valid = mem_read_valid;
          d_read_data  = mem_read_valid ? mem_read_data : 32'd0;
        end
        if (mem_read_valid && own_read_ack) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_holy_mem_arbiter.sv
// Self-checking bench for holy_mem_arbiter: vector table, directed sequences,
// and a randomized phase checked against a transaction-level scoreboard.
`default_nettype none

module tb_holy_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_address, i_write_data, d_address, d_write_data;
  logic [3:0]  i_byte_enable, d_byte_enable;
  logic        i_req_valid, i_req_write, i_read_ack;
  logic        d_req_valid, d_req_write, d_read_ack;
  logic        i_req_ready, i_read_valid, d_req_ready, d_read_valid;
  logic [31:0] i_read_data, d_read_data;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_req_valid, mem_req_write, mem_req_ready, mem_read_valid, mem_read_ack;

  always #5 clk = ~clk;

  holy_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_write_data(i_write_data), .i_byte_enable(i_byte_enable),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_ready(i_req_ready),
    .i_read_data(i_read_data), .i_read_valid(i_read_valid), .i_read_ack(i_read_ack),
    .d_address(d_address), .d_write_data(d_write_data), .d_byte_enable(d_byte_enable),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_ready(d_req_ready),
    .d_read_data(d_read_data), .d_read_valid(d_read_valid), .d_read_ack(d_read_ack),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_req_valid(mem_req_valid),
    .mem_req_write(mem_req_write), .mem_req_ready(mem_req_ready),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .mem_read_ack(mem_read_ack)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {i_req_ready, d_req_ready, i_read_valid, d_read_valid, mem_req_valid,
                       mem_read_ack, mem_req_write, mem_byte_enable, i_read_data, d_read_data}, 0);
    chk({nm, "_mem"}, {mem_address, mem_write_data}, 0);
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] smem [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  bit mem_auto = 0, rand_lat = 0, chk_on = 0;
  int req_lat = 0, rd_lat = 1, wcnt = 0, rcnt = 0;
  bit pend = 0;
  logic [31:0] pend_addr;

  // Values observed mid-cycle, i.e. what the following rising edge acted on.
  logic s_hs, s_wr, s_rdone;
  logic [31:0] s_addr, s_wd;
  logic [3:0]  s_be;
  logic s_acc [2];
  logic s_rdn [2];

  initial forever begin
    @(negedge clk);
    s_hs = mem_req_valid & mem_req_ready;  s_wr = mem_req_write;
    s_addr = mem_address;  s_wd = mem_write_data;  s_be = mem_byte_enable;
    s_rdone = mem_read_valid & mem_read_ack;
    s_acc[0] = i_req_valid & i_req_ready;  s_acc[1] = d_req_valid & d_req_ready;
    s_rdn[0] = i_read_valid & i_read_ack;  s_rdn[1] = d_read_valid & d_read_ack;
  end

  function automatic int next_req_lat();
    return rand_lat ? int'($urandom_range(0, 2)) : req_lat;
  endfunction

  initial forever begin
    @(posedge clk); #2;
    if (!rst_n || !mem_auto) begin
      mem_req_ready = 0; mem_read_valid = 0; mem_read_data = $urandom;
      pend = 0; wcnt = next_req_lat();
    end else begin
      if (s_rdone) begin mem_read_valid = 0; mem_read_data = $urandom; end
      if (s_hs) begin
        mem_req_ready = 0; wcnt = next_req_lat();
        if (s_wr) rmem[s_addr] = merge(rmem_rd(s_addr), s_wd, s_be);
        else begin
          pend = 1; pend_addr = s_addr;
          rcnt = rand_lat ? int'($urandom_range(1, 3)) : rd_lat;
        end
      end else if (pend) begin
        rcnt--;
        if (rcnt <= 0) begin pend = 0; mem_read_valid = 1; mem_read_data = rmem_rd(pend_addr); end
      end else if (!mem_req_valid) begin
        mem_req_ready = 0; wcnt = next_req_lat();
      end else if (!mem_req_ready) begin
        if (wcnt <= 0) mem_req_ready = 1; else wcnt--;
      end
    end
  end

  // ---------------- transaction-level scoreboard ----------------
  bit m_free = 1, m_resp = 0;
  int m_own = 0, m_last = 0, n_done = 0, w;
  logic [31:0] m_exp;
  logic pv[2], pw[2], prd[2], prv[2], pk[2];
  logic [31:0] pa[2], pwd[2], prdat[2];
  logic [3:0]  pbe[2];

  initial forever begin
    @(negedge clk);
    if (chk_on && rst_n) begin
      pv = '{i_req_valid, d_req_valid};     pw = '{i_req_write, d_req_write};
      prd = '{i_req_ready, d_req_ready};    prv = '{i_read_valid, d_read_valid};
      pk = '{i_read_ack, d_read_ack};       pa = '{i_address, d_address};
      pwd = '{i_write_data, d_write_data};  prdat = '{i_read_data, d_read_data};
      pbe = '{i_byte_enable, d_byte_enable};
      chk("rdata_zero_when_invalid", {i_read_valid ? 32'd0 : i_read_data,
                                      d_read_valid ? 32'd0 : d_read_data}, 0);
      if (m_free) begin
        chk("idle_quiet", {prd[0], prd[1], prv[0], prv[1], mem_req_valid}, 0);
        if (pv[0] || pv[1]) begin
          if (pv[0] && pv[1]) begin
`ifdef HOLY_ARB_ROUND_ROBIN_EN
            w = 1 - m_last;
`else
            w = 1;
`endif
          end else w = pv[1] ? 1 : 0;
          m_own = w; m_last = w; m_free = 0; m_resp = 0;
        end
      end else begin
        chk("nonowner_quiet", {prd[1-m_own], prv[1-m_own]}, 0);
        if (!m_resp) begin
          chk("mem_req_fields", {mem_req_valid, mem_req_write, mem_address, mem_write_data,
              mem_byte_enable}, {pv[m_own], pw[m_own], pa[m_own], pwd[m_own], pbe[m_own]});
          chk("owner_ready", prd[m_own], mem_req_ready);
          if (pv[m_own] && prd[m_own]) begin
            if (pw[m_own]) begin
              smem[pa[m_own]] = merge(smem_rd(pa[m_own]), pwd[m_own], pbe[m_own]);
              m_free = 1; n_done++;
            end else begin
              m_exp = smem_rd(pa[m_own]); m_resp = 1;
            end
          end
        end else begin
          chk("owner_rvalid_ack", {prv[m_own], mem_read_ack}, {mem_read_valid, pk[m_own]});
          if (prv[m_own]) begin
            chk("read_data", prdat[m_own], m_exp);
            if (pk[m_own]) begin m_free = 1; n_done++; end
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    i_address = 0; i_write_data = 0; i_byte_enable = 0; i_req_valid = 0; i_req_write = 0; i_read_ack = 0;
    d_address = 0; d_write_data = 0; d_byte_enable = 0; d_req_valid = 0; d_req_write = 0; d_read_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return i_req_ready;
      1: return d_req_ready;
      2: return i_read_valid;
      3: return d_read_valid;
      4: return i_req_ready | d_req_ready;
      default: return mem_req_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string nm);
    int n = 0;
    @(negedge clk);
    while (!cond(which) && n < 40) begin @(negedge clk); n++; end
    chk(nm, cond(which), 1);
  endtask

  typedef struct {
    logic iv, dv, iw, dw;
    logic [31:0] ia, da, iwd, dwd;
    logic [3:0] ibe, dbe;
    logic ev, ew;
    logic [31:0] ea, ewd;
    logic [3:0] ebe;
  } vec_t;
  vec_t tbl [5];

  int pulses, rvs, good;
  logic hs;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_be;
  logic r_on[2], r_out[2], r_w[2], r_k[2];
  logic [31:0] r_a[2], r_d[2];
  logic [3:0]  r_b[2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1,0,0,1, 32'h100, 32'h9999, 32'h1111_1111, 32'h2222_2222, 4'hF, 4'h2,
               1,0, 32'h100, 32'h1111_1111, 4'hF};
    tbl[1] = '{0,1,1,1, 32'h7777, 32'h2000, 32'h3333_3333, 32'h1234_5678, 4'h8, 4'h3,
               1,1, 32'h2000, 32'h1234_5678, 4'h3};
    tbl[2] = '{1,1,1,0, 32'h300, 32'h400, 32'hAAAA_5555, 32'h0BAD_0BAD, 4'hF, 4'h1,
               1,0, 32'h400, 32'h0BAD_0BAD, 4'h1};
    tbl[3] = '{0,0,1,1, 32'h500, 32'h600, 32'h1, 32'h2, 4'hF, 4'hF,
               0,0, 32'h0, 32'h0, 4'h0};
    tbl[4] = '{1,0,1,0, 32'h4, 32'h8, 32'hFFFF_FFFF, 32'h5, 4'h8, 4'h4,
               1,1, 32'h4, 32'hFFFF_FFFF, 4'h8};

    // Reset holds every output low regardless of inputs.
    rst_n = 0;
    i_address = 32'hFFFF_FFFF; i_write_data = 32'hFFFF_FFFF; i_byte_enable = 4'hF;
    d_address = 32'hFFFF_FFFF; d_write_data = 32'hFFFF_FFFF; d_byte_enable = 4'hF;
    i_req_valid = 1; i_req_write = 1; i_read_ack = 1;
    d_req_valid = 1; d_req_write = 1; d_read_ack = 1;
    mem_req_ready = 1; mem_read_valid = 1; mem_read_data = 32'hFFFF_FFFF;
    #3 chk_all_zero("reset");

    // Vector table: IDLE outputs, then the one-cycle grant and its mem_* fields.
    for (int k = 0; k < 5; k++) begin
      do_reset();
      i_req_valid = tbl[k].iv; d_req_valid = tbl[k].dv;
      i_req_write = tbl[k].iw; d_req_write = tbl[k].dw;
      i_address = tbl[k].ia; d_address = tbl[k].da;
      i_write_data = tbl[k].iwd; d_write_data = tbl[k].dwd;
      i_byte_enable = tbl[k].ibe; d_byte_enable = tbl[k].dbe;
      i_read_ack = 1; d_read_ack = 1;
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", k), {i_req_ready, d_req_ready, i_read_valid,
          d_read_valid, mem_req_valid, mem_read_ack}, 0);
      @(negedge clk);
      if (tbl[k].ev)
        chk($sformatf("tbl%0d_grant", k), {i_req_ready, d_req_ready, mem_req_valid,
            mem_req_write, mem_byte_enable, mem_address, mem_write_data},
            {2'b00, 1'b1, tbl[k].ew, tbl[k].ebe, tbl[k].ea, tbl[k].ewd});
      else
        chk($sformatf("tbl%0d_nogrant", k), {i_req_ready, d_req_ready, mem_req_valid}, 0);
    end

    // Single I read, 3-cycle memory latency.
    mem_auto = 1; req_lat = 0; rd_lat = 3;
    rmem[32'h100] = 32'hDEAD_BEEF; rmem[32'h104] = 32'hCAFE_F00D;
    do_reset();
    i_address = 32'h100; i_req_valid = 1;
    wait_for(0, "r36_ready");
    chk("r36_addr", {mem_address, mem_req_write}, {32'h100, 1'b0});
    tick(); i_req_valid = 0;
    wait_for(2, "r36_rvalid");
    chk("r36_data", {i_read_data, d_read_valid}, {32'hDEAD_BEEF, 1'b0});
    tick(); i_read_ack = 1;
    @(negedge clk); chk("r36_ack", {mem_read_ack, i_read_valid}, 2'b11);
    tick(); i_read_ack = 0;
    @(negedge clk); chk("r36_idle", {i_read_valid, i_read_data, mem_req_valid}, 0);

    // D write with partial strobe.
    do_reset();
    d_address = 32'h2000; d_write_data = 32'h1234_5678; d_byte_enable = 4'b0011;
    d_req_write = 1; d_req_valid = 1;
    pulses = 0; rvs = 0; cap_addr = 0; cap_data = 0; cap_be = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_req_ready) pulses++;
      if (i_read_valid || d_read_valid) rvs++;
      hs = mem_req_valid & mem_req_ready;
      if (hs) begin cap_addr = mem_address; cap_data = mem_write_data; cap_be = mem_byte_enable; end
      tick();
      if (hs) d_req_valid = 0;
    end
    chk("r38_pulses", pulses, 1);
    chk("r38_no_rvalid", rvs, 0);
    chk("r38_fields", {cap_be, cap_addr, cap_data}, {4'b0011, 32'h2000, 32'h1234_5678});

    // D read held un-acked for 5 cycles while I waits.
    rd_lat = 2;
    do_reset();
    d_address = 32'h104; d_req_valid = 1;
    wait_for(1, "r39_dready");
    tick(); d_req_valid = 0; i_address = 32'h100; i_req_valid = 1;
    wait_for(3, "r39_rvalid");
    good = 0;
    for (int c = 0; c < 5; c++) begin
      if (d_read_valid && d_read_data == 32'hCAFE_F00D && !i_req_ready && !mem_req_valid) good++;
      @(negedge clk);
    end
    chk("r39_stable", good, 5);
    tick(); d_read_ack = 1;
    tick(); d_read_ack = 0;
    wait_for(0, "r39_i_grant");
    chk("r39_i_addr", mem_address, 32'h100);
    tick(); i_req_valid = 0; i_read_ack = 1;
    wait_for(2, "r39_i_rvalid");
    chk("r39_i_data", i_read_data, 32'hDEAD_BEEF);
    tick(); i_read_ack = 0;

    // Simultaneous reads right after reset.
    rd_lat = 1;
    do_reset();
    i_address = 32'h100; d_address = 32'h104; i_read_ack = 1; d_read_ack = 1;
    i_req_valid = 1; d_req_valid = 1;
    wait_for(4, "r37_first");
    chk("r37_first_is_d", {d_req_ready, i_req_ready}, 2'b10);
    tick(); d_req_valid = 0;
    wait_for(3, "r37_d_rvalid");
    chk("r37_d_data", d_read_data, 32'hCAFE_F00D);
    tick(); d_address = 32'h108; d_req_write = 1; d_req_valid = 1;
    wait_for(4, "r37_second");
`ifdef HOLY_ARB_ROUND_ROBIN_EN
    chk("r37_second_winner", {d_req_ready, i_req_ready}, 2'b01);
`else
    chk("r37_second_winner", {d_req_ready, i_req_ready}, 2'b10);
`endif

    // Owner withdraws before mem_req_ready; other port goes next.
    req_lat = 10;
    do_reset();
    i_address = 32'h100; i_req_valid = 1;
    tick(); d_address = 32'h2000; d_req_write = 1; d_req_valid = 1;
    @(negedge clk); chk("r41_i_owner", {mem_req_valid, mem_address, d_req_ready}, {1'b1, 32'h100, 1'b0});
    tick(); i_req_valid = 0;
    @(negedge clk); chk("r41_dropped", mem_req_valid, 0);
    wait_for(5, "r41_d_req");
    chk("r41_d_fields", {mem_address, mem_req_write}, {32'h2000, 1'b1});
    wait_for(1, "r41_d_ready");
    tick(); d_req_valid = 0;

    // Reset asserted in RESP, then an I read right after release.
    req_lat = 0; rd_lat = 6;
    do_reset();
    i_address = 32'h100; i_read_ack = 1; i_req_valid = 1;
    wait_for(0, "r40_ready");
    tick(); i_req_valid = 0;
    @(negedge clk); chk("r40_in_resp", {mem_read_ack, i_read_valid}, 2'b10);
    #2 rst_n = 0; i_req_valid = 1; rd_lat = 3;
    #1 chk_all_zero("r40_reset");
    @(negedge clk); rst_n = 1;
    tick(); chk("r40_first_grant", {mem_req_valid, mem_address}, {1'b1, 32'h100});
    wait_for(0, "r40_ready2");
    tick(); i_req_valid = 0;
    wait_for(2, "r40_rvalid");
    chk("r40_data", i_read_data, 32'hDEAD_BEEF);
    tick(); i_read_ack = 0;

    // Randomized traffic against the scoreboard.
    rmem.delete(); smem.delete();
    rand_lat = 1;
    do_reset();
    m_free = 1; m_resp = 0; m_last = 0; n_done = 0; chk_on = 1;
    r_on = '{0, 0}; r_out = '{0, 0}; r_w = '{0, 0}; r_k = '{0, 0};
    r_a = '{0, 0}; r_d = '{0, 0}; r_b = '{0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (r_on[p] && s_acc[p]) begin r_on[p] = 0; r_out[p] = !r_w[p]; end
        else if (r_out[p] && s_rdn[p]) r_out[p] = 0;
        if (!r_on[p] && !r_out[p] && $urandom_range(0, 2) == 0) begin
          r_on[p] = 1;
          r_w[p] = 1'($urandom_range(0, 1));
          r_a[p] = 32'h1000 + 32'(4 * $urandom_range(0, 7));
          r_d[p] = $urandom;
          r_b[p] = 4'($urandom_range(1, 15));
        end
        r_k[p] = r_out[p] && ($urandom_range(0, 1) == 1);
      end
      i_req_valid = r_on[0]; i_req_write = r_w[0]; i_address = r_a[0];
      i_write_data = r_d[0]; i_byte_enable = r_b[0]; i_read_ack = r_k[0];
      d_req_valid = r_on[1]; d_req_write = r_w[1]; d_address = r_a[1];
      d_write_data = r_d[1]; d_byte_enable = r_b[1]; d_read_ack = r_k[1];
    end
    @(negedge clk);
    chk_on = 0;
    chk("rand_progress", n_done >= 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
